// File: rtl/bno055_pkg.sv
// Shared protocol constants for the BNO055 UART responder.
// Holds the frame and response bytes, the status codes, the FSM state
// encoding and the frame-validation helper used when the length byte arrives.
package bno055_pkg;

  // Protocol bytes
  localparam logic [7:0] START       = 8'hAA;
  localparam logic [7:0] CMD_WRITE   = 8'h00;
  localparam logic [7:0] CMD_READ    = 8'h01;
  localparam logic [7:0] HDR_READ_OK = 8'hBB;
  localparam logic [7:0] HDR_STATUS  = 8'hEE;

  // Status codes carried after an EE header (ST_NONE = all checks passed)
  localparam logic [7:0] ST_NONE      = 8'h00;
  localparam logic [7:0] ST_WRITE_OK  = 8'h01;
  localparam logic [7:0] ST_BAD_ADDR  = 8'h04;
  localparam logic [7:0] ST_WRITE_DIS = 8'h05;
  localparam logic [7:0] ST_BAD_CMD   = 8'h06;
  localparam logic [7:0] ST_MAX_LEN   = 8'h08;
  localparam logic [7:0] ST_MIN_LEN   = 8'h09;
  localparam logic [7:0] ST_TIMEOUT   = 8'h0A;

  // FSM state encoding. CMD..DISCARD are contiguous: they are the
  // "inside a frame" states watched by the optional receive timeout.
  typedef logic [3:0] state_t;
  localparam state_t S_IDLE      = 4'd0;
  localparam state_t S_CMD       = 4'd1;
  localparam state_t S_REG       = 4'd2;
  localparam state_t S_LEN       = 4'd3;
  localparam state_t S_WDATA     = 4'd4;
  localparam state_t S_DISCARD   = 4'd5;
  localparam state_t S_RESP_HDR  = 4'd6;
  localparam state_t S_RESP_B1   = 4'd7;
  localparam state_t S_RESP_DATA = 4'd8;

  // Validate a frame once reg and len are known. Returns ST_NONE when the
  // frame may proceed, otherwise the highest-priority failing status
  // (min length, max length, address range, write protection).
  function automatic logic [7:0] check_frame(input logic       is_write,
                                             input logic [7:0] reg_addr,
                                             input logic [7:0] len,
                                             input logic [7:0] ro_limit);
    logic [8:0] span;
    span = {1'b0, reg_addr} + {1'b0, len};
    if (len == 8'd0)                       return ST_MIN_LEN;
    if (len > 8'd128)                      return ST_MAX_LEN;
    if (reg_addr[7] || (span > 9'd128))    return ST_BAD_ADDR;
    if (is_write && (reg_addr < ro_limit)) return ST_WRITE_DIS;
    return ST_NONE;
  endfunction

endpackage

// File: rtl/bno055_uart_responder_if.sv
// Byte-stream link between the UART receiver/transmitter and the responder.
//   rx_data/rx_valid : one-cycle strobe per received byte (towards responder)
//   tx_data/tx_valid : response byte, held until tx_ready (from responder)
//   tx_ready         : transmitter accepts when tx_valid && tx_ready
// master = UART side / host model, slave = responder.
interface bno055_uart_responder_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output rx_data, rx_valid, tx_ready,
                  input  tx_data, tx_valid);

  modport slave  (input  rx_data, rx_valid, tx_ready,
                  output tx_data, tx_valid);
endinterface

// File: rtl/bno055_regfile.sv
// 128x8 page-0 register map of the emulated BNO055.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   wr_en/wr_addr/wr_data frame write port (wins on collision)
//   inj_we/inj_addr/...   side-port write (dropped when a frame write fires)
//   rd_addr/rd_data       synchronous read port, one cycle latency
module bno055_regfile #(
  parameter logic [7:0] CHIP_ID = 8'hA0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr_en,
  input  logic [6:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       inj_we,
  input  logic [6:0] inj_addr,
  input  logic [7:0] inj_data,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0] mem [128];

  // NOTE: the map must return to its reset image whenever reset_n asserts,
  // so it is a flop array with an async reset, not an inferred RAM (RAMs
  // cannot be reset).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 128; i++) begin
        mem[i] <= (i == 0) ? CHIP_ID : 8'h00;
      end
      rd_data <= 8'h00;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge
      // values, so rd_data sees the old contents on a same-cycle write.
      if (wr_en) begin
        mem[wr_addr] <= wr_data;
      end else if (inj_we) begin
        mem[inj_addr] <= inj_data;
      end
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/bno055_uart_responder.sv
// BNO055 UART-protocol responder: parses AA-framed read/write commands,
// serves them from a 128-byte register map and streams BB/EE responses.
// Ports:
//   clk, reset_n       clock, async active-low reset
//   uart (slave)       rx byte strobe in, tx byte valid/ready out
//   inj_we/addr/data   side-port register load (ignores write protection)
//   busy               high from start byte until last response byte accepted
//   last_status        status of the most recent EE response
// Optional feature: define BNO_RX_TIMEOUT_EN to abandon a partial frame
// after TIMEOUT_CYCLES idle cycles with an EE 0A response.
module bno055_uart_responder
  import bno055_pkg::*;
#(
  parameter int         RO_LIMIT       = 8,
  parameter logic [7:0] CHIP_ID        = 8'hA0,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  bno055_uart_responder_if.slave uart,
  input  logic                   inj_we,
  input  logic [6:0]             inj_addr,
  input  logic [7:0]             inj_data,
  output logic                   busy,
  output logic [7:0]             last_status
);

  // A limit below 2 would abandon frames between back-to-back bytes.
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_t     state_q, state_d;
  logic       is_read_q, is_read_d;
  logic [7:0] reg_q, reg_d;
  logic [7:0] len_q, len_d;
  logic [7:0] cnt_q, cnt_d;        // data index: write/discard count, or next read byte
  logic [7:0] status_q, status_d;
  logic       rd_ok_q, rd_ok_d;    // response is BB+data rather than EE+status
  logic [7:0] tx_data_q, tx_data_d;
  logic       tx_valid_q, tx_valid_d;
  logic [7:0] last_status_q, last_status_d;

  logic       wr_en;
  logic [6:0] wr_addr;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] chk;
  logic       accept;
  logic       resp_err, resp_ok;
  logic [7:0] err_code;
  logic       tmo_fire;

  assign accept = tx_valid_q && uart.tx_ready;
  assign chk    = check_frame(!is_read_q, reg_q, uart.rx_data, 8'(RO_LIMIT));

  // Read address follows the *next* index, so rd_data always holds
  // mem[reg + cnt_q] and a byte can be loaded on every accept with no bubble.
  assign wr_addr = reg_q[6:0] + cnt_q[6:0];
  assign rd_addr = reg_q[6:0] + cnt_d[6:0];

  bno055_regfile #(.CHIP_ID(CHIP_ID)) u_regfile (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (uart.rx_data),
    .inj_we   (inj_we),
    .inj_addr (inj_addr),
    .inj_data (inj_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

`ifdef BNO_RX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q;
  logic             in_frame;

  assign in_frame = (state_q >= S_CMD) && (state_q <= S_DISCARD);
  assign tmo_fire = in_frame && !uart.rx_valid &&
                    (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Counts idle cycles since the last byte of the current frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q <= '0;
    end else if (!in_frame || uart.rx_valid) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end
`else
  // No timeout: a partial frame waits for its remaining bytes indefinitely.
  assign tmo_fire = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and infers a latch.
    state_d       = state_q;
    is_read_d     = is_read_q;
    reg_d         = reg_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    status_d      = status_q;
    rd_ok_d       = rd_ok_q;
    tx_data_d     = tx_data_q;
    tx_valid_d    = tx_valid_q;
    last_status_d = last_status_q;
    wr_en         = 1'b0;
    resp_err      = 1'b0;
    resp_ok       = 1'b0;
    err_code      = ST_BAD_CMD;

    case (state_q)
      S_IDLE: if (uart.rx_valid) begin
        if (uart.rx_data == START) state_d = S_CMD;
        else                       resp_err = 1'b1;
      end
      S_CMD: if (uart.rx_valid) begin
        if (uart.rx_data == CMD_WRITE || uart.rx_data == CMD_READ) begin
          is_read_d = (uart.rx_data == CMD_READ);
          state_d   = S_REG;
        end else begin
          resp_err = 1'b1;
        end
      end
      S_REG: if (uart.rx_valid) begin
        reg_d   = uart.rx_data;
        state_d = S_LEN;
      end
      S_LEN: if (uart.rx_valid) begin
        len_d = uart.rx_data;
        cnt_d = 8'd0;
        if (chk == ST_NONE) begin
          if (is_read_q) resp_ok = 1'b1;
          else           state_d = S_WDATA;
        end else if (!is_read_q && uart.rx_data != 8'd0) begin
          // A rejected write still owns its data bytes; swallow them first.
          status_d = chk;
          state_d  = S_DISCARD;
        end else begin
          resp_err = 1'b1;
          err_code = chk;
        end
      end
      S_WDATA: if (uart.rx_valid) begin
        wr_en = 1'b1;
        if (cnt_q == len_q - 8'd1) begin
          resp_err = 1'b1;
          err_code = ST_WRITE_OK;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DISCARD: if (uart.rx_valid) begin
        if (cnt_q == len_q - 8'd1) begin
          resp_err = 1'b1;
          err_code = status_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP_HDR: if (accept) begin
        tx_data_d = rd_ok_q ? len_q : status_q;
        if (!rd_ok_q) last_status_d = status_q;
        state_d = S_RESP_B1;
      end
      S_RESP_B1: if (accept) begin
        if (rd_ok_q) begin
          tx_data_d = rd_data;
          cnt_d     = cnt_q + 8'd1;
          state_d   = S_RESP_DATA;
        end else begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      S_RESP_DATA: if (accept) begin
        if (cnt_q == len_q) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end else begin
          tx_data_d = rd_data;
          cnt_d     = cnt_q + 8'd1;
        end
      end
      default: begin
        tx_valid_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase

    if (tmo_fire) begin
      resp_err = 1'b1;
      err_code = ST_TIMEOUT;
    end

    // Both response kinds start the same way: header presented next cycle.
    if (resp_err || resp_ok) begin
      state_d    = S_RESP_HDR;
      tx_valid_d = 1'b1;
      tx_data_d  = resp_ok ? HDR_READ_OK : HDR_STATUS;
      rd_ok_d    = resp_ok;
      if (resp_err) status_d = err_code;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      is_read_q     <= 1'b0;
      reg_q         <= 8'h00;
      len_q         <= 8'h00;
      cnt_q         <= 8'h00;
      status_q      <= 8'h00;
      rd_ok_q       <= 1'b0;
      tx_data_q     <= 8'h00;
      tx_valid_q    <= 1'b0;
      last_status_q <= 8'h00;
    end else begin
      state_q       <= state_d;
      is_read_q     <= is_read_d;
      reg_q         <= reg_d;
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      status_q      <= status_d;
      rd_ok_q       <= rd_ok_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      last_status_q <= last_status_d;
    end
  end

  assign uart.tx_data  = tx_data_q;
  assign uart.tx_valid = tx_valid_q;
  assign busy          = (state_q != S_IDLE);
  assign last_status   = last_status_q;

endmodule

// File: tb/tb_bno055_uart_responder.sv
// Directed self-checking bench for bno055_uart_responder.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_bno055_uart_responder;

  localparam int TMO = 200;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       inj_we;
  logic [6:0] inj_addr;
  logic [7:0] inj_data;
  logic       busy;
  logic [7:0] last_status;

  bno055_uart_responder_if uart ();

  bno055_uart_responder #(
    .RO_LIMIT       (8),
    .CHIP_ID        (8'hA0),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .uart        (uart),
    .inj_we      (inj_we),
    .inj_addr    (inj_addr),
    .inj_data    (inj_data),
    .busy        (busy),
    .last_status (last_status)
  );

  always #5 clk = ~clk;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] resp [0:131];
  int         resp_n;
  logic [7:0] exp_mem [0:127];
  int         waited;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  // Present one byte for one cycle; called and returns on a falling edge.
  task automatic send(input logic [7:0] b);
    uart.rx_data  = b;
    uart.rx_valid = 1'b1;
    @(negedge clk);
    uart.rx_valid = 1'b0;
  endtask

  // Accept n response bytes into resp[]; with stall, tx_ready toggles every
  // cycle and a held byte must not change while it waits.
  task automatic collect(input int n, input bit stall);
    int         guard;
    bit         hold;
    logic [7:0] held;
    guard  = 0;
    hold   = 1'b0;
    held   = 8'h00;
    resp_n = 0;
    while (resp_n < n && guard < 1000) begin
      if (hold) begin
        check("stall_valid", 8'(uart.tx_valid), 8'h01);
        check("stall_data", uart.tx_data, held);
      end
      uart.tx_ready = stall ? guard[0] : 1'b1;
      if (uart.tx_valid && uart.tx_ready) begin
        resp[resp_n] = uart.tx_data;
        resp_n++;
        hold = 1'b0;
      end else begin
        hold = uart.tx_valid;
        held = uart.tx_data;
      end
      @(negedge clk);
      guard++;
    end
    uart.tx_ready = 1'b0;
    check("resp_count", 8'(resp_n), 8'(n));
  endtask

  task automatic expect_resp(input string tag, input int n, input bit stall,
                             input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] bv [4];
    bv = '{b0, b1, b2, b3};
    collect(n, stall);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s.b%0d", tag, i), resp[i], bv[i]);
    end
    check({tag, ".busy_end"}, 8'(busy), 8'h00);
    check({tag, ".valid_end"}, 8'(uart.tx_valid), 8'h00);
  endtask

  // Wait (bounded) for a response to appear during a silent frame.
  task automatic wait_valid(input int limit);
    waited = 0;
    while (!uart.tx_valid && waited < limit) begin
      @(negedge clk);
      waited++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n       = 1'b0;
    uart.rx_data  = 8'h00;
    uart.rx_valid = 1'b0;
    uart.tx_ready = 1'b0;
    inj_we        = 1'b0;
    inj_addr      = 7'h00;
    inj_data      = 8'h00;
    for (int i = 0; i < 128; i++) exp_mem[i] = 8'h00;
    exp_mem[0] = 8'hA0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst.tx_valid", 8'(uart.tx_valid), 8'h00);
    check("rst.tx_data", uart.tx_data, 8'h00);
    check("rst.busy", 8'(busy), 8'h00);
    check("rst.last_status", last_status, 8'h00);
    reset_n = 1'b1;
    @(negedge clk);

    // Chip-id read; response valid one cycle after the final byte
    send(8'hAA); send(8'h01); send(8'h00);
    check("rd_chip.pre_valid", 8'(uart.tx_valid), 8'h00);
    send(8'h01);
    check("rd_chip.latency", 8'(uart.tx_valid), 8'h01);
    check("rd_chip.busy", 8'(busy), 8'h01);
    expect_resp("rd_chip", 3, 1'b0, 8'hBB, 8'h01, 8'hA0, 8'h00);
    check("rd_chip.last_status", last_status, 8'h00);

    // Two-byte write then read back
    send(8'hAA); send(8'h00); send(8'h10); send(8'h02); send(8'h12); send(8'h34);
    check("wr10.latency", 8'(uart.tx_valid), 8'h01);
    expect_resp("wr10", 2, 1'b0, 8'hEE, 8'h01, 8'h00, 8'h00);
    check("wr10.last_status", last_status, 8'h01);
    exp_mem[8'h10] = 8'h12;
    exp_mem[8'h11] = 8'h34;
    send(8'hAA); send(8'h01); send(8'h10); send(8'h02);
    expect_resp("rd10", 4, 1'b0, 8'hBB, 8'h02, 8'h12, 8'h34);

    // Write to protected register: data byte is swallowed, nothing written
    send(8'hAA); send(8'h00); send(8'h03); send(8'h01);
    check("ro03.discard_wait", 8'(uart.tx_valid), 8'h00);
    check("ro03.discard_busy", 8'(busy), 8'h01);
    send(8'h55);
    check("ro03.latency", 8'(uart.tx_valid), 8'h01);
    expect_resp("ro03", 2, 1'b0, 8'hEE, 8'h05, 8'h00, 8'h00);
    check("ro03.last_status", last_status, 8'h05);
    send(8'hAA); send(8'h01); send(8'h03); send(8'h01);
    expect_resp("rd03", 3, 1'b0, 8'hBB, 8'h01, 8'h00, 8'h00);

    // Error codes and their boundaries
    send(8'hAA); send(8'h01); send(8'h7F); send(8'h02);
    expect_resp("addr_span", 2, 1'b0, 8'hEE, 8'h04, 8'h00, 8'h00);
    send(8'hAA); send(8'h01); send(8'h01); send(8'h80);
    expect_resp("addr_129", 2, 1'b0, 8'hEE, 8'h04, 8'h00, 8'h00);
    send(8'hAA); send(8'h01); send(8'h00); send(8'h00);
    expect_resp("len0", 2, 1'b0, 8'hEE, 8'h09, 8'h00, 8'h00);
    send(8'hAA); send(8'h00); send(8'h90); send(8'h00);
    check("wlen0.latency", 8'(uart.tx_valid), 8'h01);
    expect_resp("wlen0", 2, 1'b0, 8'hEE, 8'h09, 8'h00, 8'h00);
    send(8'hAA); send(8'h01); send(8'h00); send(8'h81);
    expect_resp("len129", 2, 1'b0, 8'hEE, 8'h08, 8'h00, 8'h00);
    send(8'h55);
    check("badstart.latency", 8'(uart.tx_valid), 8'h01);
    expect_resp("badstart", 2, 1'b0, 8'hEE, 8'h06, 8'h00, 8'h00);
    send(8'hAA); send(8'h02);
    expect_resp("badcmd", 2, 1'b0, 8'hEE, 8'h06, 8'h00, 8'h00);
    check("badcmd.last_status", last_status, 8'h06);
    send(8'hAA); send(8'h00); send(8'h07); send(8'h01); send(8'h99);
    expect_resp("ro07", 2, 1'b0, 8'hEE, 8'h05, 8'h00, 8'h00);
    send(8'hAA); send(8'h00); send(8'h08); send(8'h01); send(8'h66);
    expect_resp("wr08", 2, 1'b0, 8'hEE, 8'h01, 8'h00, 8'h00);
    exp_mem[8'h08] = 8'h66;

    // Side-port loads (protection ignored), then a stalled read
    inj_we = 1'b1; inj_addr = 7'h02; inj_data = 8'h77;
    @(negedge clk);
    inj_addr = 7'h20; inj_data = 8'h9C;
    @(negedge clk);
    inj_we = 1'b0;
    exp_mem[8'h02] = 8'h77;
    exp_mem[8'h20] = 8'h9C;
    send(8'hAA); send(8'h01); send(8'h20); send(8'h01);
    expect_resp("inj20", 3, 1'b1, 8'hBB, 8'h01, 8'h9C, 8'h00);
    send(8'hAA); send(8'h01); send(8'h02); send(8'h01);
    expect_resp("inj02", 3, 1'b1, 8'hBB, 8'h01, 8'h77, 8'h00);

    // Frame write and side-port write to the same register in one cycle
    send(8'hAA); send(8'h00); send(8'h30); send(8'h01);
    inj_we = 1'b1; inj_addr = 7'h30; inj_data = 8'h77;
    send(8'h5A);
    inj_we = 1'b0;
    expect_resp("collide", 2, 1'b0, 8'hEE, 8'h01, 8'h00, 8'h00);
    exp_mem[8'h30] = 8'h5A;
    send(8'hAA); send(8'h01); send(8'h30); send(8'h01);
    expect_resp("rd30", 3, 1'b0, 8'hBB, 8'h01, 8'h5A, 8'h00);

    // Full-map read, 128 bytes back to back
    send(8'hAA); send(8'h01); send(8'h00); send(8'h80);
    collect(130, 1'b0);
    check("full.hdr", resp[0], 8'hBB);
    check("full.len", resp[1], 8'h80);
    for (int i = 0; i < 128; i++) begin
      check($sformatf("full.reg%02h", i), resp[2 + i], exp_mem[i]);
    end

`ifdef BNO_RX_TIMEOUT_EN
    // Silence inside a frame is abandoned after TMO cycles
    send(8'hAA); send(8'h00);
    wait_valid(TMO + 50);
    check("tmo.cycles", 8'(waited), 8'(TMO));
    expect_resp("tmo", 2, 1'b0, 8'hEE, 8'h0A, 8'h00, 8'h00);
    check("tmo.last_status", last_status, 8'h0A);
    send(8'hAA); send(8'h00); send(8'h40); send(8'h02); send(8'h11);
    wait_valid(TMO + 50);
    check("tmo_wr.cycles", 8'(waited), 8'(TMO));
    expect_resp("tmo_wr", 2, 1'b0, 8'hEE, 8'h0A, 8'h00, 8'h00);
    send(8'hAA); send(8'h01); send(8'h40); send(8'h01);
    expect_resp("tmo_kept", 3, 1'b0, 8'hBB, 8'h01, 8'h11, 8'h00);
`else
    // Without the timeout a partial frame just waits
    send(8'hAA); send(8'h00);
    wait_valid(TMO + 50);
    check("notmo.valid", 8'(uart.tx_valid), 8'h00);
    check("notmo.busy", 8'(busy), 8'h01);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
`endif

    // Reset mid-response: output drops, map and status revert
    send(8'hAA); send(8'h01); send(8'h10); send(8'h02);
    uart.tx_ready = 1'b1;
    @(negedge clk);
    uart.tx_ready = 1'b0;
    check("midrst.pre_valid", 8'(uart.tx_valid), 8'h01);
    check("midrst.pre_data", uart.tx_data, 8'h02);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst.valid", 8'(uart.tx_valid), 8'h00);
    check("midrst.busy", 8'(busy), 8'h00);
    check("midrst.last_status", last_status, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send(8'hAA); send(8'h01); send(8'h10); send(8'h02);
    expect_resp("postrst10", 4, 1'b0, 8'hBB, 8'h02, 8'h00, 8'h00);
    send(8'hAA); send(8'h01); send(8'h00); send(8'h01);
    expect_resp("postrst00", 3, 1'b0, 8'hBB, 8'h01, 8'hA0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
